// File: rtl/mips_cpu_pkg.sv
// Shared core definitions: fetch FSM states and architectural constants
// reused by the PC, fetch and decode stages.
package mips_cpu_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] NOP_INSTR    = 32'h00000000;
    localparam logic [31:0] HALT_ADDR    = 32'h00000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/mips_cpu_fetch_if.sv
// Instruction memory bus. Handshake: a transfer completes on the first cycle
// where instr_read=1 and instr_waitrequest=0; until then address/read are held.
interface mips_cpu_fetch_if;

    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_waitrequest;
    logic [31:0] instr_readdata;

    modport master (
        output instr_address,
        output instr_read,
        input  instr_waitrequest,
        input  instr_readdata
    );

    modport slave (
        input  instr_address,
        input  instr_read,
        output instr_waitrequest,
        output instr_readdata
    );

endinterface

// File: rtl/mips_cpu_fetch.sv
// Instruction-fetch stage: one outstanding read, holds the returned word until
// the consumer acks, stops at HALT_ADDR or on a misaligned PC.
module mips_cpu_fetch #(
    parameter logic [31:0] NOP_INSTR = 32'h00000000,
    parameter logic [31:0] HALT_ADDR = 32'h00000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                pc_in,
    input  logic                       pc_active,
    input  logic                       instr_ack,
    input  logic                       flush,
    mips_cpu_fetch_if.master           mem,
    output logic [31:0]                instr_out,
    output logic                       instr_valid,
    output logic                       stall,
    output logic                       halted,
    output logic                       fetch_fault,
    output mips_cpu_pkg::fetch_state_t state_dbg
);

    import mips_cpu_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic         read_q, read_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic         stall_q, stall_d;
    logic         halted_q, halted_d;
    logic         fault_q, fault_d;
    logic         discard_q, discard_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        read_d    = read_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        stall_d   = stall_q;
        halted_d  = halted_q;
        fault_d   = fault_q;
        discard_d = discard_q;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    instr_d = NOP_INSTR;
                end else if (!pc_active) begin
                    stall_d = 1'b0;
                end else if (pc_in == HALT_ADDR) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                    stall_d  = 1'b0;
                    instr_d  = NOP_INSTR;
                end else if (pc_in[1:0] != 2'b00) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                    stall_d = 1'b0;
                    instr_d = NOP_INSTR;
                end else begin
                    state_d = REQ;
                    addr_d  = pc_in;
                    read_d  = 1'b1;
                    stall_d = 1'b1;
                end
            end

            REQ: begin
                // A flush never abandons the bus: the read finishes, its data is dropped.
                if (!mem.instr_waitrequest) begin
                    read_d    = 1'b0;
                    discard_d = 1'b0;
                    if (flush || discard_q) begin
                        state_d = IDLE;
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                        stall_d = 1'b1;
                    end else begin
                        state_d = HOLD;
                        instr_d = mem.instr_readdata;
                        valid_d = 1'b1;
                        stall_d = 1'b0;
                    end
                end else if (flush) begin
                    discard_d = 1'b1;
                end
            end

            HOLD: begin
                if (flush) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    stall_d = 1'b1;
                end else if (instr_ack) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    stall_d = 1'b1;
                end
            end

            HALT: begin
                read_d  = 1'b0;
                valid_d = 1'b0;
                stall_d = 1'b0;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= 32'h0;
            read_q    <= 1'b0;
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
            stall_q   <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            read_q    <= read_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            stall_q   <= stall_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
            discard_q <= discard_d;
        end
    end

    assign mem.instr_address = addr_q;
    assign mem.instr_read    = read_q;
    assign instr_out         = instr_q;
    assign instr_valid       = valid_q;
    assign stall             = stall_q;
    assign halted            = halted_q;
    assign fetch_fault       = fault_q;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// Directed bench for the fetch stage: inputs change and outputs are sampled
// on the falling clock edge, away from the active rising edge.
module tb_mips_cpu_fetch;
    import mips_cpu_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [31:0]  pc_in;
    logic         pc_active;
    logic         instr_ack;
    logic         flush;
    logic [31:0]  instr_out;
    logic         instr_valid;
    logic         stall;
    logic         halted;
    logic         fetch_fault;
    fetch_state_t state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    mips_cpu_fetch_if bus ();

    mips_cpu_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_in       (pc_in),
        .pc_active   (pc_active),
        .instr_ack   (instr_ack),
        .flush       (flush),
        .mem         (bus.master),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .stall       (stall),
        .halted      (halted),
        .fetch_fault (fetch_fault),
        .state_dbg   (state_dbg)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle_inputs();
        pc_in                 = 32'h0;
        pc_active             = 1'b0;
        instr_ack             = 1'b0;
        flush                 = 1'b0;
        bus.instr_waitrequest = 1'b0;
        bus.instr_readdata    = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n                 = 1'b0;
        pc_in                 = RESET_VECTOR;
        pc_active             = 1'b1;
        instr_ack             = 1'b0;
        flush                 = 1'b0;
        bus.instr_waitrequest = 1'b0;
        bus.instr_readdata    = 32'h24020005;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.instr_read !== 1'b0) $display("FAIL rst_read got %b want 0", bus.instr_read); else n_pass++;
        n_checks++; if (bus.instr_address !== 32'h0) $display("FAIL rst_addr got %h want 00000000", bus.instr_address); else n_pass++;
        n_checks++; if (instr_out !== 32'h0) $display("FAIL rst_instr got %h want 00000000", instr_out); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", instr_valid); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL rst_stall got %b want 0", stall); else n_pass++;
        n_checks++; if ({halted, fetch_fault} !== 2'b00) $display("FAIL rst_flags got %b want 00", {halted, fetch_fault}); else n_pass++;
        n_checks++; if (state_dbg !== IDLE) $display("FAIL rst_state got %0d want 0", state_dbg); else n_pass++;
        rst_n = 1'b1;
    endtask

    // Continues straight from test_reset: first fetch out of reset, zero wait.
    task automatic test_basic_fetch();
        @(negedge clk);
        n_checks++; if (bus.instr_read !== 1'b1) $display("FAIL e1_read got %b want 1", bus.instr_read); else n_pass++;
        n_checks++; if (bus.instr_address !== 32'hBFC00000) $display("FAIL e1_addr got %h want bfc00000", bus.instr_address); else n_pass++;
        n_checks++; if ({instr_valid, stall} !== 2'b01) $display("FAIL e1_valid_stall got %b want 01", {instr_valid, stall}); else n_pass++;
        @(negedge clk);
        n_checks++; if (instr_out !== 32'h24020005) $display("FAIL e2_instr got %h want 24020005", instr_out); else n_pass++;
        n_checks++; if ({instr_valid, stall, bus.instr_read} !== 3'b100) $display("FAIL e2_valid_stall_read got %b want 100", {instr_valid, stall, bus.instr_read}); else n_pass++;
        bus.instr_readdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if ({instr_valid, instr_out} !== {1'b1, 32'h24020005}) $display("FAIL hold_word got %b/%h want 1/24020005", instr_valid, instr_out); else n_pass++;
        end
        instr_ack = 1'b1;
        @(negedge clk);
        n_checks++; if ({instr_valid, stall} !== 2'b01) $display("FAIL ack_valid_stall got %b want 01", {instr_valid, stall}); else n_pass++;
        n_checks++; if (state_dbg !== IDLE) $display("FAIL ack_state got %0d want 0", state_dbg); else n_pass++;
        instr_ack          = 1'b0;
        pc_in              = 32'hBFC00004;
        bus.instr_readdata = 32'h8C430000;
        @(negedge clk);
        n_checks++; if ({bus.instr_read, bus.instr_address} !== {1'b1, 32'hBFC00004}) $display("FAIL next_req got %b/%h want 1/bfc00004", bus.instr_read, bus.instr_address); else n_pass++;
        @(negedge clk);
        n_checks++; if ({instr_valid, instr_out} !== {1'b1, 32'h8C430000}) $display("FAIL next_word got %b/%h want 1/8c430000", instr_valid, instr_out); else n_pass++;
        instr_ack = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0;
        pc_active = 1'b0;
        @(negedge clk);
        n_checks++; if ({stall, bus.instr_read, instr_valid} !== 3'b000) $display("FAIL inactive got %b want 000", {stall, bus.instr_read, instr_valid}); else n_pass++;
    endtask

    task automatic test_wait_states();
        do_reset();
        pc_in                 = RESET_VECTOR;
        pc_active             = 1'b1;
        bus.instr_waitrequest = 1'b1;
        bus.instr_readdata    = 32'hAAAA5555;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_checks++; if ({bus.instr_read, bus.instr_address} !== {1'b1, 32'hBFC00000}) $display("FAIL wait_req%0d got %b/%h want 1/bfc00000", i, bus.instr_read, bus.instr_address); else n_pass++;
            n_checks++; if ({instr_valid, stall} !== 2'b01) $display("FAIL wait_stall%0d got %b want 01", i, {instr_valid, stall}); else n_pass++;
        end
        bus.instr_waitrequest = 1'b0;
        @(negedge clk);
        n_checks++; if ({instr_valid, instr_out, bus.instr_read} !== {1'b1, 32'hAAAA5555, 1'b0}) $display("FAIL wait_done got %b/%h/%b want 1/aaaa5555/0", instr_valid, instr_out, bus.instr_read); else n_pass++;
    endtask

    task automatic test_halt();
        do_reset();
        pc_in     = HALT_ADDR;
        pc_active = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++; if ({halted, bus.instr_read, stall, instr_valid} !== 4'b1000) $display("FAIL halt_c%0d got %b want 1000", i, {halted, bus.instr_read, stall, instr_valid}); else n_pass++;
            // A later valid PC, flush or ack must not wake a halted stage.
            if (i == 5) pc_in = 32'hBFC00000;
            flush     = (i == 8);
            instr_ack = (i == 9);
        end
        n_checks++; if (state_dbg !== HALT) $display("FAIL halt_state got %0d want 3", state_dbg); else n_pass++;
    endtask

    task automatic test_fault();
        do_reset();
        pc_in     = 32'hBFC00002;
        pc_active = 1'b1;
        @(negedge clk);
        n_checks++; if ({fetch_fault, halted, bus.instr_read, stall} !== 4'b1000) $display("FAIL fault_set got %b want 1000", {fetch_fault, halted, bus.instr_read, stall}); else n_pass++;
        pc_in = 32'hBFC00008;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if ({fetch_fault, bus.instr_read} !== 2'b10) $display("FAIL fault_hold%0d got %b want 10", i, {fetch_fault, bus.instr_read}); else n_pass++;
        end
    endtask

    task automatic test_flush_req();
        do_reset();
        pc_in                 = RESET_VECTOR;
        pc_active             = 1'b1;
        bus.instr_waitrequest = 1'b1;
        bus.instr_readdata    = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++; if (bus.instr_read !== 1'b1) $display("FAIL fl_req got %b want 1", bus.instr_read); else n_pass++;
        flush = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus.instr_read, bus.instr_address} !== {1'b1, 32'hBFC00000}) $display("FAIL fl_held1 got %b/%h want 1/bfc00000", bus.instr_read, bus.instr_address); else n_pass++;
        flush = 1'b0;
        pc_in = 32'hBFC00100;
        @(negedge clk);
        n_checks++; if ({bus.instr_read, instr_valid} !== 2'b10) $display("FAIL fl_held2 got %b want 10", {bus.instr_read, instr_valid}); else n_pass++;
        bus.instr_waitrequest = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.instr_read, instr_valid, stall} !== 3'b001) $display("FAIL fl_discard got %b want 001", {bus.instr_read, instr_valid, stall}); else n_pass++;
        n_checks++; if (instr_out !== 32'h0) $display("FAIL fl_nop got %h want 00000000", instr_out); else n_pass++;
        bus.instr_readdata = 32'h3C01BFC0;
        @(negedge clk);
        n_checks++; if ({bus.instr_read, bus.instr_address} !== {1'b1, 32'hBFC00100}) $display("FAIL fl_refetch got %b/%h want 1/bfc00100", bus.instr_read, bus.instr_address); else n_pass++;
        @(negedge clk);
        n_checks++; if ({instr_valid, instr_out} !== {1'b1, 32'h3C01BFC0}) $display("FAIL fl_word got %b/%h want 1/3c01bfc0", instr_valid, instr_out); else n_pass++;
        flush     = 1'b1;
        instr_ack = 1'b1;
        @(negedge clk);
        n_checks++; if ({instr_valid, instr_out} !== {1'b0, 32'h0}) $display("FAIL fl_hold got %b/%h want 0/00000000", instr_valid, instr_out); else n_pass++;
        flush     = 1'b0;
        instr_ack = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        pc_in                 = RESET_VECTOR;
        pc_active             = 1'b1;
        bus.instr_waitrequest = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus.instr_read, stall} !== 2'b11) $display("FAIL ar_pre got %b want 11", {bus.instr_read, stall}); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.instr_read, instr_valid, stall} !== 3'b000) $display("FAIL ar_drop got %b want 000", {bus.instr_read, instr_valid, stall}); else n_pass++;
        @(negedge clk);
        bus.instr_waitrequest = 1'b0;
        bus.instr_readdata    = 32'h11112222;
        rst_n                 = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus.instr_read, bus.instr_address} !== {1'b1, 32'hBFC00000}) $display("FAIL ar_restart got %b/%h want 1/bfc00000", bus.instr_read, bus.instr_address); else n_pass++;
        @(negedge clk);
        n_checks++; if ({instr_valid, instr_out} !== {1'b1, 32'h11112222}) $display("FAIL ar_word got %b/%h want 1/11112222", instr_valid, instr_out); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle_inputs();
        test_reset();
        test_basic_fetch();
        test_wait_states();
        test_halt();
        test_fault();
        test_flush_req();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_cpu_fetch.md
Name: mips_cpu_fetch

Overview:
- Instruction-fetch stage directly downstream of mips_cpu_pc: takes the current program counter and its active flag.
- Issues a read on the instruction memory bus (read/waitrequest handshake) and holds the returned word in an instruction register.
- The held word is the `instr` consumed by the decoder and fed back to mips_cpu_pc for branch/jump target formation.
- Back-pressures the core with `stall` until the word is valid, and reports halt (PC = 0) and misaligned-PC faults.

Parameters:
- NOP_INSTR, 32'h00000000, value driven on instr_out after reset, flush or fault.
- HALT_ADDR, 32'h00000000, PC value that terminates fetching.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_in  in  32  current PC (mips_cpu_pc pc_out)
- pc_active  in  1  PC stage active flag
- instr_ack  in  1  consumer accepted instr_out this cycle (PC advances same edge)
- flush  in  1  discard in-flight/held word (exception/redirect)
- instr_address  out  32  memory address, byte-addressed, word aligned
- instr_read  out  1  memory read request
- instr_waitrequest  in  1  memory not ready; request must be held
- instr_readdata  in  32  memory read data, valid when read && !waitrequest
- instr_out  out  32  held instruction word
- instr_valid  out  1  instr_out holds a word for pc_in
- stall  out  1  = !instr_valid while fetching; freezes the core
- halted  out  1  fetch stopped at HALT_ADDR (sticky until reset)
- fetch_fault  out  1  pc_in[1:0] != 0 (sticky until reset)

Behaviour:
- Reset (async, rst_n low) drives: state=IDLE, instr_read=0, instr_address=0, instr_out=NOP_INSTR, instr_valid=0, stall=0, halted=0, fetch_fault=0. All outputs are registered.
- FSM states: IDLE, REQ, HOLD, HALT.
- IDLE:
  - pc_active=0: remain in IDLE, stall=0.
  - pc_in==HALT_ADDR: go to HALT, halted<=1.
  - pc_in[1:0]!=0: go to HALT, fetch_fault<=1, no read.
  - Otherwise: instr_address<=pc_in, instr_read<=1, stall<=1, go to REQ.
- REQ:
  - instr_read and instr_address stay constant while instr_waitrequest=1, for an unbounded wait.
  - First cycle with waitrequest=0: instr_out<=instr_readdata, instr_valid<=1, instr_read<=0, stall<=0, go to HOLD.
  - Minimum latency pc_in -> instr_valid is 2 cycles (IDLE edge + REQ edge with zero wait).
- HOLD:
  - instr_out and instr_valid remain stable until instr_ack.
  - On instr_ack: instr_valid<=0, stall<=1, go to IDLE. The next pc_in is sampled in IDLE on the following cycle.
  - instr_ack outside HOLD is ignored.
- HALT: absorbing state; instr_read=0, instr_valid=0, stall=0. Left only by reset.
- flush:
  - Highest priority after reset.
  - In REQ with waitrequest=1: the request is completed (read held until waitrequest=0), but the data is discarded, then go to IDLE. The bus protocol is never abandoned mid-transfer.
  - In REQ with waitrequest=0: discard the data, go to IDLE.
  - In HOLD: instr_valid<=0, instr_out<=NOP_INSTR, go to IDLE.
  - flush together with instr_ack: flush wins.
- pc_active falling while in REQ: the transfer completes normally. A falling pc_active is re-examined only in IDLE.
- No byte swapping: instr_out = instr_readdata verbatim.
- Only one outstanding read at a time; no prefetch.

Decomposition:
- Shared package mips_cpu_pkg gets:
  - typedef enum fetch_state_t {IDLE, REQ, HOLD, HALT};
  - constants RESET_VECTOR=32'hBFC00000, NOP_INSTR, HALT_ADDR, for reuse by mips_cpu_pc and the decoder.
- No sub-module; a single FSM with registered outputs.

Test Plan:
- Reset release with pc_in=32'hBFC00000, pc_active=1, waitrequest=0, readdata=32'h24020005:
  - instr_read=1, addr=BFC00000 at edge 1;
  - instr_out=24020005, instr_valid=1, stall=0 at edge 2;
  - held until instr_ack.
- Same fetch with waitrequest high for 3 cycles: instr_read and address stable for 4 cycles; valid one cycle after waitrequest drops.
- pc_in=32'h00000000 with pc_active=1: halted=1, instr_read never asserted, stall=0; remains so for 20 cycles.
- pc_in=32'hBFC00002: fetch_fault=1, no read issued.
- flush during REQ with waitrequest=1 for 2 cycles:
  - read held until waitrequest=0;
  - readdata discarded (instr_valid stays 0);
  - new fetch of the updated pc_in=32'hBFC00100 follows.
- rst_n asserted asynchronously mid-REQ: instr_read, instr_valid and stall drop immediately, without waiting for a clock edge; after release, fetch restarts from pc_in.
